// File: rtl/arb_mux_pkg.sv
// Shared constants for the N:1 valid/ready arbitrating mux.
package arb_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first requesting channel found by
// searching upward from (last + 1) mod N with wrap-around.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 hit,
    output logic [$clog2(N)-1:0] idx
);

    localparam int SELW = $clog2(N);

    int pos;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last) + k) % N;
            if (req[pos]) begin
                hit = 1'b1;
                idx = SELW'(pos);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel valid/ready mux with explicit-select and round-robin modes,
// forwarding the chosen beat through a one-entry registered output stage.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    grant_idx
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  grant_q,     grant_d;
    logic [SELW-1:0]  last_q,      last_d;

    logic             load_en;
    logic             rr_hit;
    logic [SELW-1:0]  rr_idx;
    logic             hit;
    logic [SELW-1:0]  cand;
    logic [WIDTH-1:0] cand_data;
    logic             xfer;

    rr_pick #(.N(N)) u_rr_pick (
        .req  (in_valid),
        .last (last_q),
        .hit  (rr_hit),
        .idx  (rr_idx)
    );

    assign load_en = !out_valid_q || out_ready;

    // Choose the candidate channel; an out-of-range sel never matches any channel.
    always_comb begin
        hit  = 1'b0;
        cand = '0;
        if (mode == MODE_RR) begin
            hit  = rr_hit;
            cand = rr_idx;
        end else begin
            cand = sel;
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i)) hit = in_valid[i];
            end
        end
    end

    // Route the candidate's data and raise ready only on the candidate channel.
    always_comb begin
        cand_data = '0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (cand == SELW'(i)) begin
                cand_data   = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && hit;
            end
        end
    end

    assign xfer = load_en && hit;

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        grant_d     = grant_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = cand_data;
            out_valid_d = 1'b1;
            grant_d     = cand;
            if (mode == MODE_RR) last_d = cand;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and pointer; reset points last at N-1 so search begins at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            last_q      <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_idx = grant_q;

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised successor to the team's fixed 4:1 combinational mux.
- Selects one of N valid/ready input channels of WIDTH bits and forwards it through a one-entry registered output stage.
- Two modes:
  - sel-driven: an explicit index picks the channel, as the 4:1 mux does.
  - round-robin: fair arbitration among all valid channels.
- Sits between multiple producers and a single consumer in the datapath.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data bits per channel.
- SELW, $clog2(N), localparam; width of the index fields. Not overridable.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = sel-driven, 1 = round-robin; sampled every cycle.
- sel  input  SELW  channel index used in mode 0; ignored in mode 1.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered; output stage holds a beat.
- out_ready  input  1  consumer accepts the beat.
- grant_idx  output  SELW  registered; index of the channel currently in the output stage.

Behaviour:
- Reset (async assert, sync-safe deassert by integrator):
  - out_valid=0, out_data=0, grant_idx=0.
  - Round-robin pointer last=N-1, so the first search starts at channel 0.
- load_en = !out_valid || out_ready. The stage accepts a new beat whenever empty or draining this cycle.
- Pick logic (combinational):
  - mode 0: candidate = sel. hit = (sel < N) && in_valid[sel].
  - mode 1: candidate = first i with in_valid[i] set, searching (last+1) mod N upward with wrap. hit = |in_valid.
- in_ready[i] = load_en && hit && (i == candidate). It depends combinationally on in_valid; producers must not make in_valid depend on in_ready.
- Transfer on an input occurs when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= that channel's data.
  - out_valid <= 1.
  - grant_idx <= i.
  - In mode 1 only, last <= i. last is unchanged in mode 0.
- Output drain: out_valid && out_ready with no new transfer → out_valid <= 0. out_data and grant_idx hold their last values.
- Simultaneous drain and load: back-to-back with no bubble; throughput is 1 beat/clk.
- Latency: input accept to out_valid is exactly 1 clk.
- Stall: out_valid && !out_ready → all in_ready=0; out_data, out_valid and grant_idx are stable.
- Out-of-range sel in mode 0 (N not a power of 2, sel>=N): no grant, all in_ready=0, no X propagation.
- Mode change mid-stream:
  - Takes effect on the next pick.
  - A beat already in the output stage is unaffected.
  - last keeps its value, so round-robin resumes after the last RR grant.
- Fairness: in mode 1 with all channels continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0. No channel waits more than N-1 grants.
- Reset mid-operation: the held beat is discarded (out_valid drops asynchronously). No partial transfer is reported.

Decomposition:
- Shared package arb_mux_pkg: constants MODE_SEL=1'b0 and MODE_RR=1'b1.
- One sub-module, rr_pick:
  - Parameter N.
  - Inputs: req[N-1:0], last[SELW-1:0].
  - Outputs: hit, idx[SELW-1:0].
  - Purely combinational rotating priority encoder (double-width request vector or masked two-pass search). Reused by future arbiters.
- Top level holds: mode/sel selection, handshake, output register and pointer.

Test Plan (N=4, WIDTH=8):
1. Reset, then mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 → in_ready=4'b0100. Next clk: out_valid=1, out_data=A5, grant_idx=2.
2. mode=0, sel=1, in_valid=4'b0100 (selected channel idle) → in_ready=0000. out_valid drops to 0 after the current beat drains.
3. mode=1, in_valid=4'b1111, data ch_i=8'h10+i, out_ready=1 for 8 clks → out_data sequence 10,11,12,13,10,11,12,13 with no bubbles.
4. mode=1, out_ready=0 for 3 clks with a beat held (out_data=11) → in_ready=0000 and out_data/grant_idx stable. Raise out_ready → next grant is channel 2.
5. mode=1, in_valid=4'b1001 after grant to ch0 → next grant ch3, then ch0 (wrap-around).
6. Assert rst while out_valid=1 and out_ready=0 → out_valid=0, grant_idx=0 immediately (before the clock edge). After release, first RR grant with in_valid=1111 is ch0.
